// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM state encoding.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state;

endpackage : uart_pkg

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input bit.
// RST_VAL sets the value both flops take in reset (1 for an idle-high line).
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture of the asynchronous input to settle metastability.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule : uart_sync2

// File: rtl/uart_rx.sv
// UART receiver: start/data/stop framing with mid-bit sampling, a valid/ready
// output word, single-cycle frame-error and overrun pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int data_len = 15,
   parameter int clk_div  = 100
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                rx_in,
   input  logic                rx_ready,
   output logic [data_len-1:0] rx_data,
   output logic                rx_valid,
   output logic                frame_err,
   output logic                overrun,
   output logic                rx_busy
);

   localparam int CNT_W = $clog2(clk_div);
   localparam int BIT_W = $clog2(data_len) + 1;

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(clk_div / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(clk_div - 1);
   localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(data_len - 1);

   logic                rxs;
   state                state_q,     state_d;
   logic [CNT_W-1:0]    clk_cnt_q,   clk_cnt_d;
   logic [BIT_W-1:0]    bit_cnt_q,   bit_cnt_d;
   logic [data_len-1:0] shift_q,     shift_d;
   logic [data_len:0]   shift_ext_s;
   logic [data_len-1:0] rx_data_q,   rx_data_d;
   logic                rx_valid_q,  rx_valid_d;
   logic                frame_err_q, frame_err_d;
   logic                overrun_q,   overrun_d;
   logic                rx_busy_q,   rx_busy_d;

   uart_sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (rx_in),
      .q_o   (rxs)
   );

   // Next-state and next-output decisions, all driven from the synchronised line.
   always_comb begin
      state_d     = state_q;
      clk_cnt_d   = clk_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      // New bit enters at the MSB so the first bit on the line ends up in bit 0.
      shift_ext_s = {rxs, shift_q};

      // Consumer handshake drains the held word.
      if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end else begin
         rx_valid_d = rx_valid_q;
      end

      case (state_q)
         S_IDLE: begin
            clk_cnt_d = {CNT_W{1'b0}};
            bit_cnt_d = {BIT_W{1'b0}};
            if (!rxs) begin
               state_d = S_START;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (clk_cnt_q == HALF_LAST) begin
               clk_cnt_d = {CNT_W{1'b0}};
               // Line back high at mid start bit means a glitch, not a frame.
               if (!rxs) begin
                  state_d = S_DATA;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (clk_cnt_q == FULL_LAST) begin
               clk_cnt_d = {CNT_W{1'b0}};
               shift_d   = shift_ext_s[data_len:1];
               if (bit_cnt_q == BITS_LAST) begin
                  bit_cnt_d = {BIT_W{1'b0}};
                  state_d   = S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         S_STOP: begin
            if (clk_cnt_q == FULL_LAST) begin
               clk_cnt_d = {CNT_W{1'b0}};
               if (rxs) begin
                  // Return to idle now, leaving half a bit to catch the next start edge.
                  state_d = S_IDLE;
                  if (!rx_valid_q || rx_ready) begin
                     rx_data_d  = shift_q;
                     rx_valid_d = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_BREAK;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end
         S_BREAK: begin
            clk_cnt_d = {CNT_W{1'b0}};
            // A line held low must return high before a new start is accepted.
            if (rxs) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_BREAK;
            end
         end
         default: begin
            state_d   = S_IDLE;
            clk_cnt_d = {CNT_W{1'b0}};
            bit_cnt_d = {BIT_W{1'b0}};
         end
      endcase

      rx_busy_d = (state_d != S_IDLE);
   end

   // FSM state, counters, shift register and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         clk_cnt_q   <= {CNT_W{1'b0}};
         bit_cnt_q   <= {BIT_W{1'b0}};
         shift_q     <= {data_len{1'b0}};
         rx_data_q   <= {data_len{1'b0}};
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         rx_busy_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         clk_cnt_q   <= clk_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         rx_busy_q   <= rx_busy_d;
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign rx_busy   = rx_busy_q;

endmodule : uart_rx
